// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM encodings,
// register addresses on the 5-bit peripheral bus, and source limits.
package irq_pkg;

    localparam int IRQ_MAX_SRCS = 8;
    // Winner index width (enough for IRQ_MAX_SRCS sources).
    localparam int IRQ_WIN_W    = 3;
    // Stored active id; ACTIVE reads back {in_service, active_id}.
    localparam int IRQ_ID_W     = 4;

    localparam logic [1:0] IRQ_IDLE    = 2'd0;
    localparam logic [1:0] IRQ_REQ     = 2'd1;
    localparam logic [1:0] IRQ_SERVICE = 2'd2;

    localparam logic [4:0] IRQ_A_MASK   = 5'b11000;
    localparam logic [4:0] IRQ_A_PEND   = 5'b11001;
    localparam logic [4:0] IRQ_A_ACTIVE = 5'b11010;
    localparam logic [4:0] IRQ_A_EOI    = 5'b11011;

    typedef logic [IRQ_ID_W-1:0] irq_id_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// prio_enc: combinational fixed-priority encoder, lowest set index wins.
module prio_enc
    import irq_pkg::*;
#(
    parameter int SRCS = 4
) (
    input  logic [SRCS-1:0]      req,
    output logic [IRQ_WIN_W-1:0] id,
    output logic                 valid
);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        id = '0;
        for (int i = SRCS - 1; i >= 0; i--) begin
            if (req[i]) id = IRQ_WIN_W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, masked, fixed-priority interrupt controller
// driving the CPU EXL/IV inputs. Optional IRQ_SYNC_EN adds a 2-flop
// synchronizer on irq_in so raw asynchronous pads can be connected.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SRCS = 4,
    parameter int wide = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SRCS-1:0] irq_in,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [wide-1:0] dataIn,
    input  logic            ack,
    output logic            EXL,
    output logic            IV,
    output logic [wide-1:0] rdata
);

    logic [SRCS-1:0]      irq_s, irq_q, rise, pending, mask, live, w1c, ack_clr;
    logic [1:0]           state, state_nx;
    logic [IRQ_WIN_W-1:0] win_id;
    logic                 win_vld, req, take;
    logic                 wr_mask, wr_pend, wr_eoi;
    irq_id_t              active_id;
    logic                 unused_data;

`ifdef IRQ_SYNC_EN
    logic [SRCS-1:0] sync1, sync2;

    // Two-flop synchronizer for asynchronous sources.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    assign irq_s = irq_in;
`endif

    // Only dataIn[SRCS-1:0] carries register content.
    assign unused_data = ^dataIn;

    assign rise    = irq_s & ~irq_q;
    assign live    = pending & mask;
    assign req     = |live;
    assign wr_mask = we && (addr == IRQ_A_MASK);
    assign wr_pend = we && (addr == IRQ_A_PEND);
    // A simultaneous ack takes precedence; the EOI is dropped.
    assign wr_eoi  = we && (addr == IRQ_A_EOI) && !ack;
    assign take    = (state == IRQ_REQ) && req && ack;
    assign w1c     = wr_pend ? dataIn[SRCS-1:0] : '0;
    assign ack_clr = take ? (SRCS'(1) << win_id) : '0;

    prio_enc #(.SRCS(SRCS)) u_prio (
        .req   (live),
        .id    (win_id),
        .valid (win_vld)
    );

    // Edge capture and pending latch; a new edge wins over any clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq_s;
            pending <= (pending & ~w1c & ~ack_clr) | rise;
        end
    end

    // Software mask register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         mask <= '0;
        else if (wr_mask) mask <= dataIn[SRCS-1:0];
    end

    // Next-state logic: REQ drops back if the request is withdrawn.
    always_comb begin
        state_nx = state;
        case (state)
            IRQ_IDLE:    if (req) state_nx = IRQ_REQ;
            IRQ_REQ:     if (!req) state_nx = IRQ_IDLE;
                         else if (ack) state_nx = IRQ_SERVICE;
            IRQ_SERVICE: if (wr_eoi) state_nx = IRQ_IDLE;
            default:     state_nx = IRQ_IDLE;
        endcase
    end

    // State and captured winner id.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IRQ_IDLE;
            active_id <= '0;
        end else begin
            state <= state_nx;
            if (take) active_id <= irq_id_t'(win_id);
        end
    end

    assign EXL = (state == IRQ_REQ);
    assign IV  = EXL && win_vld && (win_id != '0);

    // Register read mux; EOI and unmapped addresses read as zero.
    always_comb begin
        rdata = '0;
        case (addr)
            IRQ_A_MASK:   rdata = wide'(mask);
            IRQ_A_PEND:   rdata = wide'(pending);
            IRQ_A_ACTIVE: rdata = wide'({state == IRQ_SERVICE, active_id});
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: table of per-cycle vectors fed through
// a scoreboard queue, plus hand-written reset sequences.
module tb_irq_ctrl;

    localparam int SRCS = 4;
    localparam int W    = 32;
    localparam logic [4:0] A_MASK = 5'h18, A_PEND = 5'h19, A_ACT = 5'h1A, A_EOI = 5'h1B;
`ifdef IRQ_SYNC_EN
    localparam int PAD = 2;
`else
    localparam int PAD = 0;
`endif

    typedef struct {
        logic            we;
        logic [4:0]      addr;
        logic [W-1:0]    data;
        logic [SRCS-1:0] irq;
        logic            ack;
        logic            exl;
        logic            iv;
        logic [W-1:0]    rd;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [SRCS-1:0] irq_in;
    logic            we;
    logic [4:0]      addr;
    logic [W-1:0]    dataIn;
    logic            ack;
    logic            EXL, IV;
    logic [W-1:0]    rdata;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    vec_t sb[$];
    logic [SRCS-1:0] prev_irq;

    irq_ctrl #(.SRCS(SRCS), .wide(W)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .addr(addr),
        .dataIn(dataIn), .ack(ack), .EXL(EXL), .IV(IV), .rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic w, logic [4:0] a, logic [W-1:0] d,
                                logic [SRCS-1:0] i, logic k,
                                logic x, logic v, logic [W-1:0] r);
        vec_t t;
        t.we = w; t.addr = a; t.data = d; t.irq = i; t.ack = k;
        t.exl = x; t.iv = v; t.rd = r;
        return t;
    endfunction

    task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Apply one vector for one clock edge and compare after the edge.
    task automatic step(vec_t v, int idx);
        vec_t e;
        // Hold a fresh rising edge through the synchronizer so the vector
        // lands on the edge where the rise reaches the edge detector.
        if (|(v.irq & ~prev_irq)) begin
            for (int p = 0; p < PAD; p++) begin
                we = 1'b0; ack = 1'b0; irq_in = v.irq; addr = v.addr;
                @(posedge clk); #1;
            end
        end
        we = v.we; addr = v.addr; dataIn = v.data; irq_in = v.irq; ack = v.ack;
        prev_irq = v.irq;
        sb.push_back(v);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk($sformatf("vec%0d EXL", idx), W'(EXL), W'(e.exl));
        chk($sformatf("vec%0d IV", idx), W'(IV), W'(e.iv));
        chk($sformatf("vec%0d rdata@%0h", idx, e.addr), rdata, e.rd);
        we = 1'b0; ack = 1'b0;
    endtask

    initial begin
        // 2: basic path, source 0
        tbl.push_back(mk(1, A_MASK, 32'h1, 4'h0, 0, 0, 0, 32'h1));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h1, 0, 0, 0, 32'h1));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 1, 0, 0, 32'h10));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, A_EOI,  32'h0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 0, 0, 0, 32'h0));
        // 3: priority takeover before ack, then re-request after EOI
        tbl.push_back(mk(1, A_MASK, 32'hF, 4'h0, 0, 0, 0, 32'hF));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h4, 0, 0, 0, 32'h4));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h4, 0, 1, 1, 32'h4));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h6, 0, 1, 1, 32'h6));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h6, 1, 0, 0, 32'h11));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h0, 0, 0, 0, 32'h4));
        tbl.push_back(mk(1, A_EOI,  32'h0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 0, 1, 1, 32'h1));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 1, 0, 0, 32'h12));
        // ack + EOI together in SERVICE: EOI dropped
        tbl.push_back(mk(1, A_EOI,  32'h0, 4'h0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 0, 0, 0, 32'h12));
        tbl.push_back(mk(1, A_EOI,  32'h0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 0, 0, 0, 32'h2));
        // ack in IDLE ignored
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 1, 0, 0, 32'h2));
        // 4: mask withdraw while in REQ
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h8, 0, 0, 0, 32'h8));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h0, 0, 1, 1, 32'h8));
        tbl.push_back(mk(1, A_MASK, 32'h0, 4'h0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h0, 0, 0, 0, 32'h8));
        // 5: W1C colliding with a rise on bit 1; set wins, bit 3 clears
        tbl.push_back(mk(1, A_PEND, 32'hA, 4'h2, 0, 0, 0, 32'h2));
        tbl.push_back(mk(1, A_PEND, 32'h2, 4'h2, 0, 0, 0, 32'h0));
        // upper data bits ignored
        tbl.push_back(mk(1, A_MASK, 32'hFFFF_FFF5, 4'h2, 0, 0, 0, 32'h5));
        // enter SERVICE for the async reset check
        tbl.push_back(mk(0, A_PEND, 32'h0, 4'h3, 0, 0, 0, 32'h1));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 0, 1, 0, 32'h2));
        tbl.push_back(mk(0, A_ACT,  32'h0, 4'h0, 1, 0, 0, 32'h10));

        // 1: reset with all sources high
        rst = 1'b0; irq_in = 4'hF; we = 1'b0; ack = 1'b0; addr = '0; dataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset EXL", W'(EXL), '0);
        chk("reset IV", W'(IV), '0);
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            chk($sformatf("reset rdata@%0h", a), rdata, '0);
        end
        irq_in = 4'h0;
        prev_irq = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) step(tbl[i], i);

        // 6: asynchronous reset between edges while in SERVICE
        addr = A_MASK;
        #1;
        chk("pre-reset MASK", rdata, 32'h5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async EXL", W'(EXL), '0);
        addr = A_ACT;
        #1;
        chk("async ACTIVE", rdata, '0);
        addr = A_MASK;
        #1;
        chk("async MASK", rdata, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post-reset EXL", W'(EXL), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
